uart_rx_fifo: RTL
=================

# uart_rx_fifo

Serial UART receiver with an 8N1 deframer, mid-bit sampling and a small output FIFO. It is the receive end of the SoC's `uart0_tx` line and is instantiated in the simulation bench and in the FPGA top-level capture path. It delivers received bytes to a consumer over a valid/ready interface.

## Interface

Parameters:
- `DIV`, default 868: `sys_clk` cycles per bit, 100 MHz / 115200. Must be ≥ 4 and even.
- `FIFO_DEPTH`, default 4: number of FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `sys_clk` in, 1: single clock for all logic.
- `sys_rst` in, 1: reset, synchronous and active-high.
- `rx` in, 1: asynchronous serial input; idle level is high.
- `out_data` out, 8: head-of-FIFO byte; meaningful only while `out_valid` is high.
- `out_valid` out, 1: FIFO not empty.
- `out_ready` in, 1: consumer accepts `out_data` this cycle.
- `frame_err` out, 1: one-cycle pulse; stop bit sampled low.
- `parity_err` out, 1: one-cycle pulse; parity mismatch. Tied 0 without the macro.
- `overrun` out, 1: one-cycle pulse; a good byte was dropped because the FIFO was full.
- `busy` out, 1: high in any state other than IDLE.

## Operation

- `rx` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rxs`.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- **IDLE:** when `rxs`==0, go to START and load the bit counter with DIV/2−1.
- **START:** when the counter reaches 0, sample `rxs`.
  - 0: go to DATA, counter = DIV−1, bit index = 0.
  - 1: treat as a glitch and return to IDLE with no error.
- **DATA:** sample at each counter expiry and shift in LSB first. After bit 7, go to PARITY or STOP with counter = DIV−1.
- **PARITY:** the sampled bit must equal the XOR of the 8 data bits (even parity).
- **STOP:** on counter expiry, sample `rxs`.
  - 1 and no parity error: push the byte, go to IDLE.
  - 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - 1 with a parity error: pulse `parity_err`, discard the byte, go to IDLE.
- **WAIT_IDLE:** stay until `rxs`==1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- **FIFO:** show-ahead, with pointer width log2(FIFO_DEPTH)+1.
  - Pop when `out_valid && out_ready`.
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun` pulses.
  - FIFO contents are never corrupted by an overrun.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `frame_err`=`parity_err`=`overrun`=0, `busy`=0, FSM=IDLE, FIFO empty, synchronizer=1.
- Let S be the first cycle with `rxs`==0 in IDLE.
  - Start sample at S+DIV/2.
  - Data bit k sampled at S+DIV/2+(k+1)·DIV.
  - Stop sample at S+DIV/2+9·DIV, or +10·DIV with parity.
- The push, or the error/overrun pulse, is registered in the stop-sample cycle and is visible the next cycle. `out_valid` rises 1 cycle after the stop sample.
- Error and overrun pulses are exactly 1 cycle wide.
- Back-to-back frames: IDLE is entered at the mid-stop point, so a start edge arriving half a bit later is detected.
- `sys_rst` mid-frame: next cycle is IDLE with an empty FIFO, and no pulses are produced. Reset has priority over all events.
- Pop on an empty FIFO is ignored. `out_data` is held stable while `out_valid` is high and `out_ready` is low.

## Configuration

- `UART_RX_PARITY_EN`
  - Defined: frame is 8E1. The PARITY state exists and `parity_err` is driven as described above.
  - Undefined: frame is 8N1. The PARITY state is not compiled in and `parity_err` is constant 0.

## Test plan

All scenarios use DIV=16, FIFO_DEPTH=4, `out_ready`=1 unless stated.
- Send 0x55, then 0xA3 back-to-back → `out_data` 0x55 then 0xA3, each with `out_valid` asserted once. No error pulses.
- Drive `rx` low for 4 cycles, then high → `busy` returns to 0 after the start sample. No `out_valid`, no errors.
- Send 0x3C with the stop bit held low for 40 bit times → exactly one `frame_err` pulse, no byte output, `busy` stays high until `rx` returns high.
- `out_ready`=0, send 0x01–0x05 → FIFO holds 0x01–0x04 and `overrun` pulses once on 0x05. Then `out_ready`=1 → 0x01, 0x02, 0x03, 0x04 are delivered in order.
- Assert `sys_rst` for 1 cycle during data bit 3 of 0x7E, then send 0x81 → only 0x81 is received.
- Macro defined: send 0xA5 with parity 0 (correct) → byte output. Resend with parity 1 → one `parity_err` pulse, no byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- UART receiver (8N1, or 8E1 with the macro) with a small
// show-ahead output FIFO and a valid/ready consumer interface.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : 8E1 frames, PARITY state present, parity_err driven
//   undefined : 8N1 frames, parity_err tied 0
//
// Parameters:
//   DIV        sys_clk cycles per bit (>= 4, even)
//   FIFO_DEPTH FIFO entries (power of 2, >= 2)
//
// Ports:
//   sys_clk    in   single clock
//   sys_rst    in   synchronous active-high reset
//   rx         in   asynchronous serial input, idle high
//   out_data   out  head-of-FIFO byte, valid while out_valid
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes out_data this cycle
//   frame_err  out  1-cycle pulse, stop bit sampled low
//   parity_err out  1-cycle pulse, parity mismatch
//   overrun    out  1-cycle pulse, good byte dropped on a full FIFO
//   busy       out  receiver not idle
module uart_rx_fifo #(
   parameter int DIV        = 868,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       rx,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(DIV);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
   localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   // ---------------------------------------------------------------
   // Input synchronizer (resets to the idle level so reset never
   // looks like a start edge)
   // ---------------------------------------------------------------
   logic rx_meta_q, rxs_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rxs_q     <= rx_meta_q;
      end
   end

   // ---------------------------------------------------------------
   // Deframer FSM
   // ---------------------------------------------------------------
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          frame_err_q, frame_err_d;
   logic          overrun_q, overrun_d;
   logic          push;
   logic          expire;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_q, par_bad_d;
   logic          parity_err_q, parity_err_d;
`endif

   assign expire = (cnt_q == '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (!rxs_q) begin
               state_d = S_START;
               cnt_d   = HALF_M1;
            end
         end
         S_START: begin
            if (expire) begin
               // A high line at mid-start is a glitch: drop silently.
               if (!rxs_q) begin
                  state_d = S_DATA;
                  cnt_d   = FULL_M1;
                  bit_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DATA: begin
            if (expire) begin
               shift_d = {rxs_q, shift_q[7:1]};   // LSB arrives first
               cnt_d   = FULL_M1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (expire) begin
               // Even parity: line bit must equal XOR of the data bits.
               par_bad_d = rxs_q ^ (^shift_q);
               state_d   = S_STOP;
               cnt_d     = FULL_M1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`endif
         S_STOP: begin
            if (expire) begin
               if (!rxs_q) begin
                  frame_err_d = 1'b1;
                  state_d     = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_q) begin
                  parity_err_d = 1'b1;
                  state_d      = S_IDLE;
`endif
               end else begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_WAIT_IDLE: begin
            // Holding here across a break yields a single frame_err.
            if (rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   // ---------------------------------------------------------------
   // Show-ahead FIFO; pointers carry one extra bit so full and empty
   // are told apart by the difference.
   // ---------------------------------------------------------------
   logic [FIFO_DEPTH-1:0][7:0] mem_q;
   logic [AW:0]                wr_ptr_q, rd_ptr_q, count;
   logic                       pop, full, push_ok;

   assign count     = wr_ptr_q - rd_ptr_q;
   assign out_valid = (count != '0);
   assign full      = (count == DEPTH_V);
   assign pop       = out_valid && out_ready;
   // On a full FIFO a simultaneous pop frees the slot being written.
   assign push_ok   = push && (!full || pop);
   assign overrun_d = push && !push_ok;
   assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
            wr_ptr_q                <= wr_ptr_q + (AW + 1)'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      end
   end

endmodule
